// File: rtl/ycr1_wbb_arb.sv
// ---------------------------------------------------------------------------
// ycr1_wbb_arb
//
// Round-robin arbiter that shares one burst-capable Wishbone master port
// between N requesters (instruction cache, data cache, debug/DMA). The shared
// port drives the master side of the async Wishbone bridge. A grant is held
// from the first strobe until the burst ends (last ack, error, requester
// withdrawal or watchdog expiry). Each burst is followed by one idle GAP cycle
// with strobe low, which the bridge needs.
//
// Ports
//   wbm_clk_i, wbm_rst_i        clock, synchronous active-high reset
//   m_cyc_i/m_stb_i/m_we_i      per-requester control, one bit each
//   m_adr_i/m_dat_i/m_sel_i/... per-requester command, packed k*W +: W
//   m_bl_i
//   m_dat_o                     shared read data (valid with requester's ack)
//   m_ack_o/m_lack_o/m_err_o    per-requester responses (granted index only)
//   s_*_o                       command towards the bridge
//   s_dat_i/s_ack_i/s_lack_i/   responses from the bridge
//   s_err_i
//
// Parameters
//   N       number of requesters (2..8)
//   AW/DW   address / data width
//   BW      byte-select width
//   BL      burst-count width
//   TO_CYC  watchdog limit in cycles without ack while granted (0 = off)
// ---------------------------------------------------------------------------
module ycr1_wbb_arb #(
    parameter int N      = 3,
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int BW     = 4,
    parameter int BL     = 10,
    parameter int TO_CYC = 1023
) (
    input  logic            wbm_clk_i,
    input  logic            wbm_rst_i,

    input  logic [N-1:0]    m_cyc_i,
    input  logic [N-1:0]    m_stb_i,
    input  logic [N*AW-1:0] m_adr_i,
    input  logic [N-1:0]    m_we_i,
    input  logic [N*DW-1:0] m_dat_i,
    input  logic [N*BW-1:0] m_sel_i,
    input  logic [N*BL-1:0] m_bl_i,
    output logic [DW-1:0]   m_dat_o,
    output logic [N-1:0]    m_ack_o,
    output logic [N-1:0]    m_lack_o,
    output logic [N-1:0]    m_err_o,

    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic [AW-1:0]   s_adr_o,
    output logic            s_we_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [BW-1:0]   s_sel_o,
    output logic [BL-1:0]   s_bl_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_lack_i,
    input  logic            s_err_i
);

    localparam int IW  = (N > 1) ? $clog2(N) : 1;
    localparam int WDW = (TO_CYC > 1) ? $clog2(TO_CYC + 1) : 1;

    localparam logic [IW-1:0]  LAST_RST = IW'(N - 1);
    localparam logic [WDW-1:0] WD_LAST  = WDW'((TO_CYC > 0) ? TO_CYC - 1 : 0);
    localparam logic [IW:0]    N_EXT    = (IW + 1)'(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   gnt_idx;
    logic [IW-1:0]   gnt_nxt;
    logic [IW-1:0]   last_idx;
    logic [IW-1:0]   last_nxt;
    logic [WDW-1:0]  wd_cnt;

    logic            pick_vld;
    logic [IW-1:0]   pick_idx;
    logic            wd_exp;
    logic            busy_end;

    // Unpacked views of the packed per-requester command buses.
    logic [AW-1:0]   adr_a [N];
    logic [DW-1:0]   dat_a [N];
    logic [BW-1:0]   sel_a [N];
    logic [BL-1:0]   bl_a  [N];

    for (genvar k = 0; k < N; k++) begin : g_unpack
        assign adr_a[k] = m_adr_i[k*AW +: AW];
        assign dat_a[k] = m_dat_i[k*DW +: DW];
        assign sel_a[k] = m_sel_i[k*BW +: BW];
        assign bl_a[k]  = m_bl_i[k*BL +: BL];
    end

    // Round-robin pick: scan last_idx+1, last_idx+2, ... wrapping at N, so
    // the previous winner is considered last and only re-wins when alone.
    always_comb begin : p_pick
        logic [IW:0] cand;
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = 1; i <= N; i++) begin
            cand = {1'b0, last_idx} + (IW + 1)'(i);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (!pick_vld && m_stb_i[cand[IW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[IW-1:0];
            end
        end
    end

    // Watchdog fires on the TO_CYC-th consecutive BUSY cycle without an ack.
    assign wd_exp = (TO_CYC > 0) && (state == BUSY) && (wd_cnt == WD_LAST) && !s_ack_i;

    assign busy_end = s_lack_i || s_err_i || wd_exp ||
                      (!m_stb_i[gnt_idx] && !s_ack_i);

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_idx;
        last_nxt  = last_idx;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    gnt_nxt   = pick_idx;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (busy_end) begin
                    state_nxt = GAP;
                    last_nxt  = gnt_idx;
                end
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wbm_clk_i) begin
        if (wbm_rst_i) begin
            state    <= IDLE;
            gnt_idx  <= '0;
            last_idx <= LAST_RST;
        end else begin
            state    <= state_nxt;
            gnt_idx  <= gnt_nxt;
            last_idx <= last_nxt;
        end
    end

    // Held at zero outside BUSY, which covers the clear on entry to BUSY and
    // keeps stray acks in IDLE/GAP from touching it. Saturates, never wraps.
    always_ff @(posedge wbm_clk_i) begin
        if (wbm_rst_i) begin
            wd_cnt <= '0;
        end else if (state != BUSY || s_ack_i) begin
            wd_cnt <= '0;
        end else if (wd_cnt != WD_LAST) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Output mux: everything is zero unless a grant is active.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_adr_o  = '0;
        s_we_o   = 1'b0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_bl_o   = '0;
        m_dat_o  = '0;
        m_ack_o  = '0;
        m_lack_o = '0;
        m_err_o  = '0;
        if (state == BUSY) begin
            s_cyc_o           = m_cyc_i[gnt_idx];
            s_stb_o           = m_stb_i[gnt_idx];
            s_adr_o           = adr_a[gnt_idx];
            s_we_o            = m_we_i[gnt_idx];
            s_dat_o           = dat_a[gnt_idx];
            s_sel_o           = sel_a[gnt_idx];
            s_bl_o            = bl_a[gnt_idx];
            m_dat_o           = s_dat_i;
            m_ack_o[gnt_idx]  = s_ack_i;
            m_lack_o[gnt_idx] = s_lack_i || wd_exp;
            m_err_o[gnt_idx]  = s_err_i || wd_exp;
        end
    end

endmodule

// File: tb/tb_ycr1_wbb_arb.sv
module tb_ycr1_wbb_arb;

    localparam int N = 3, AW = 32, DW = 32, BW = 4, BL = 10, TO_CYC = 16;

    logic            wbm_clk_i = 1'b0;
    logic            wbm_rst_i;
    logic [N-1:0]    m_cyc, m_stb, m_we;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat;
    logic [N*BW-1:0] m_sel;
    logic [N*BL-1:0] m_bl;
    logic [DW-1:0]   m_dat_o;
    logic [N-1:0]    m_ack_o, m_lack_o, m_err_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [BW-1:0]   s_sel_o;
    logic [BL-1:0]   s_bl_o;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack_i, s_lack_i, s_err_i;

    int n_cmp = 0;
    int n_bad = 0;
    int nack;
    int nlack;

    always #5 wbm_clk_i = ~wbm_clk_i;

    ycr1_wbb_arb #(.N(N), .AW(AW), .DW(DW), .BW(BW), .BL(BL), .TO_CYC(TO_CYC)) dut (
        .wbm_clk_i(wbm_clk_i), .wbm_rst_i(wbm_rst_i),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_adr_i(m_adr), .m_we_i(m_we),
        .m_dat_i(m_dat), .m_sel_i(m_sel), .m_bl_i(m_bl),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_lack_o(m_lack_o), .m_err_o(m_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_adr_o(s_adr_o), .s_we_o(s_we_o),
        .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_bl_o(s_bl_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_lack_i(s_lack_i), .s_err_i(s_err_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] adr_of(input logic [1:0] k);
        return 32'h1000_0000 + {22'd0, k, 8'd0};
    endfunction

    task automatic set_req(input logic [1:0] k, input logic on, input logic we,
                           input logic [9:0] bl);
        m_cyc[k]            = on;
        m_stb[k]            = on;
        m_we[k]             = we;
        m_adr[k*AW +: AW]   = adr_of(k);
        m_dat[k*DW +: DW]   = 32'hD000_0000 + {30'd0, k};
        m_sel[k*BW +: BW]   = 4'hF;
        m_bl[k*BL +: BL]    = bl;
    endtask

    task automatic tick();
        @(posedge wbm_clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic bridge(input logic ack, input logic lack, input logic err);
        s_ack_i  = ack;
        s_lack_i = lack;
        s_err_i  = err;
    endtask

    task automatic do_reset();
        wbm_rst_i = 1'b1;
        m_cyc = '0; m_stb = '0; m_we = '0;
        bridge(1'b0, 1'b0, 1'b0);
        tick();
        wbm_rst_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1);
    end

    initial begin
        logic [2:0] e;
        m_adr = '0; m_dat = '0; m_sel = '0; m_bl = '0;
        s_dat_i = 32'hCAFE_0001;
        do_reset();
        wbm_rst_i = 1'b1;
        tick();

        // ---------------- reset state
        settle();
        chk("rst cyc", 64'(s_cyc_o), 0);
        chk("rst stb", 64'(s_stb_o), 0);
        chk("rst adr", 64'(s_adr_o), 0);
        chk("rst dat_o", 64'(m_dat_o), 0);
        chk("rst ack", 64'(m_ack_o), 0);
        chk("rst gnt", 64'(dut.gnt_idx), 0);
        chk("rst last", 64'(dut.last_idx), 2);
        chk("rst wd", 64'(dut.wd_cnt), 0);
        wbm_rst_i = 1'b0;

        // ---------------- single read burst, req1, bl=4
        do_reset();
        set_req(2'd1, 1'b1, 1'b0, 10'd4);
        settle();
        chk("t1 idle stb", 64'(s_stb_o), 0);
        tick();
        nack = 0; nlack = 0;
        for (int b = 1; b <= 4; b++) begin
            bridge(1'b1, b == 4, 1'b0);
            s_dat_i = 32'hA000_0000 + 32'(b);
            settle();
            if (b == 1) begin
                chk("t1 stb", 64'(s_stb_o), 1);
                chk("t1 adr", 64'(s_adr_o), 64'(adr_of(2'd1)));
                chk("t1 bl", 64'(s_bl_o), 4);
                chk("t1 we", 64'(s_we_o), 0);
            end
            chk("t1 ack", 64'(m_ack_o), 64'(3'b010));
            chk("t1 rdata", 64'(m_dat_o), 64'(32'hA000_0000 + 32'(b)));
            nack  += int'(m_ack_o[1]);
            nlack += int'(m_lack_o[1]);
            tick();
        end
        chk("t1 ack count", 64'(nack), 4);
        chk("t1 lack count", 64'(nlack), 1);
        bridge(1'b0, 1'b0, 1'b0);
        set_req(2'd1, 1'b1, 1'b0, 10'd4);
        settle();
        chk("t1 gap stb", 64'(s_stb_o), 0);
        tick();
        set_req(2'd1, 1'b0, 1'b0, 10'd4);
        bridge(1'b1, 1'b0, 1'b0);
        settle();
        chk("t1 idle ack ignored", 64'(m_ack_o), 0);
        tick();

        // ---------------- round robin, all three requesting bl=1 writes
        do_reset();
        for (int k = 0; k < 3; k++) set_req(2'(k), 1'b1, 1'b1, 10'd1);
        settle();
        chk("t2 idle stb", 64'(s_stb_o), 0);
        tick();
        for (int g = 0; g < 6; g++) begin
            e = 3'b001 << (g % 3);
            bridge(1'b1, 1'b1, 1'b0);
            settle();
            chk("t2 adr", 64'(s_adr_o), 64'(adr_of(2'(g % 3))));
            chk("t2 ack onehot", 64'(m_ack_o), 64'(e));
            chk("t2 we", 64'(s_we_o), 1);
            tick();
            bridge(1'b0, 1'b0, 1'b0);
            settle();
            chk("t2 gap stb", 64'(s_stb_o), 0);
            tick();
            tick();
        end
        m_stb = '0; m_cyc = '0;
        tick();

        // ---------------- no pre-emption
        do_reset();
        set_req(2'd0, 1'b1, 1'b0, 10'd8);
        tick();
        for (int b = 1; b <= 8; b++) begin
            if (b == 3) set_req(2'd2, 1'b1, 1'b0, 10'd1);
            bridge(1'b1, b == 8, 1'b0);
            settle();
            chk("t3 adr held", 64'(s_adr_o), 64'(adr_of(2'd0)));
            chk("t3 ack", 64'(m_ack_o), 64'(3'b001));
            tick();
        end
        set_req(2'd0, 1'b0, 1'b0, 10'd8);
        bridge(1'b0, 1'b0, 1'b0);
        settle();
        chk("t3 gap stb", 64'(s_stb_o), 0);
        tick();
        settle();
        chk("t3 idle stb", 64'(s_stb_o), 0);
        tick();
        bridge(1'b1, 1'b1, 1'b0);
        settle();
        chk("t3 req2 stb", 64'(s_stb_o), 1);
        chk("t3 req2 adr", 64'(s_adr_o), 64'(adr_of(2'd2)));
        chk("t3 req2 ack", 64'(m_ack_o), 64'(3'b100));
        tick();
        m_stb = '0; m_cyc = '0;
        bridge(1'b0, 1'b0, 1'b0);
        tick();

        // ---------------- error on beat 2 from req2
        do_reset();
        set_req(2'd2, 1'b1, 1'b0, 10'd4);
        tick();
        bridge(1'b1, 1'b0, 1'b0);
        settle();
        chk("t4 beat1 ack", 64'(m_ack_o), 64'(3'b100));
        tick();
        bridge(1'b0, 1'b0, 1'b1);
        settle();
        chk("t4 err", 64'(m_err_o), 64'(3'b100));
        chk("t4 err ack", 64'(m_ack_o), 0);
        tick();
        bridge(1'b0, 1'b0, 1'b0);
        set_req(2'd0, 1'b1, 1'b0, 10'd1);
        set_req(2'd1, 1'b1, 1'b0, 10'd1);
        settle();
        chk("t4 gap stb", 64'(s_stb_o), 0);
        chk("t4 last", 64'(dut.last_idx), 2);
        tick();
        settle();
        chk("t4 idle stb", 64'(s_stb_o), 0);
        tick();
        settle();
        chk("t4 next adr", 64'(s_adr_o), 64'(adr_of(2'd0)));
        m_stb = '0; m_cyc = '0;
        tick();

        // ---------------- watchdog, never acked
        do_reset();
        set_req(2'd0, 1'b1, 1'b0, 10'd4);
        tick();
        for (int c = 1; c <= 16; c++) begin
            settle();
            chk("t5 wd err", 64'(m_err_o), (c == 16) ? 64'(3'b001) : 64'd0);
            chk("t5 wd lack", 64'(m_lack_o), (c == 16) ? 64'(3'b001) : 64'd0);
            tick();
        end
        set_req(2'd0, 1'b0, 1'b0, 10'd4);
        settle();
        chk("t5 gap cyc", 64'(s_cyc_o), 0);
        tick();
        settle();
        chk("t5 idle state", 64'(dut.state), 0);

        // ---------------- watchdog restarted by an ack
        set_req(2'd0, 1'b1, 1'b0, 10'd4);
        tick();
        for (int c = 1; c <= 27; c++) begin
            bridge(c == 11, 1'b0, 1'b0);
            settle();
            chk("t5b wd err", 64'(m_err_o), (c == 27) ? 64'(3'b001) : 64'd0);
            tick();
        end
        bridge(1'b0, 1'b0, 1'b0);
        set_req(2'd0, 1'b0, 1'b0, 10'd4);
        tick();

        // ---------------- reset mid-burst
        do_reset();
        set_req(2'd0, 1'b1, 1'b0, 10'd1);
        tick();
        bridge(1'b1, 1'b1, 1'b0);
        tick();
        bridge(1'b0, 1'b0, 1'b0);
        set_req(2'd0, 1'b0, 1'b0, 10'd1);
        set_req(2'd1, 1'b1, 1'b0, 10'd4);
        tick();
        tick();
        bridge(1'b1, 1'b0, 1'b0);
        settle();
        chk("t6 beat1 ack", 64'(m_ack_o), 64'(3'b010));
        tick();
        wbm_rst_i = 1'b1;
        tick();
        wbm_rst_i = 1'b0;
        set_req(2'd1, 1'b0, 1'b0, 10'd4);
        set_req(2'd0, 1'b1, 1'b0, 10'd1);
        set_req(2'd2, 1'b1, 1'b0, 10'd1);
        s_dat_i = 32'h1234_5678;
        settle();
        chk("t6 rst cyc", 64'(s_cyc_o), 0);
        chk("t6 rst stb", 64'(s_stb_o), 0);
        chk("t6 rst adr", 64'(s_adr_o), 0);
        chk("t6 rst ack", 64'(m_ack_o), 0);
        chk("t6 rst lack", 64'(m_lack_o), 0);
        chk("t6 rst dat_o", 64'(m_dat_o), 0);
        tick();
        settle();
        chk("t6 regrant stb", 64'(s_stb_o), 1);
        chk("t6 regrant adr", 64'(s_adr_o), 64'(adr_of(2'd0)));
        chk("t6 regrant ack", 64'(m_ack_o), 64'(3'b001));
        bridge(1'b0, 1'b0, 1'b0);
        m_stb = '0; m_cyc = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
